// File: rtl/stream_arbiter_pkg.sv
// Shared stream-arbiter types: FSM state encoding and a width helper.
package stream_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Ceiling log2 that never returns less than 1, so a select bus always exists.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/stream_arbiter_rr_pick.sv
// Round-robin picker: first valid index strictly after i_ptr, wrapping.
module stream_arbiter_rr_pick #(
  parameter int unsigned NumStreams = 4,
  parameter int unsigned SelWidth   = 2
) (
  input  logic [NumStreams-1:0] i_valid,
  input  logic [SelWidth-1:0]   i_ptr,
  output logic                  o_found,
  output logic [SelWidth-1:0]   o_index
);

  // Walk candidates farthest-first so the nearest valid one is written last.
  always_comb begin
    int unsigned cand;
    cand    = 0;
    o_found = 1'b0;
    o_index = '0;
    for (int unsigned k = NumStreams; k >= 1; k--) begin
      cand = 32'(i_ptr) + k;
      if (cand >= NumStreams) cand = cand - NumStreams;
      if (i_valid[SelWidth'(cand)]) begin
        o_found = 1'b1;
        o_index = SelWidth'(cand);
      end
    end
  end

endmodule

// File: rtl/stream_arbiter.sv
// Packet-aware round-robin arbiter sharing one valid/ready stream between inputs.
// Define STREAM_ARBITER_OUT_REG_EN to add a 2-entry skid register on the output.
module stream_arbiter
  import stream_arbiter_pkg::*;
#(
  parameter int unsigned NumStreams = 4,
  parameter int unsigned DataWidth  = 8,
  parameter int unsigned SelWidth   = clog2_min1(NumStreams)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NumStreams-1:0]           in_valid,
  output logic [NumStreams-1:0]           in_ready,
  input  logic [NumStreams*DataWidth-1:0] in_data,
  input  logic [NumStreams-1:0]           in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DataWidth-1:0]            out_data,
  output logic                            out_last,
  output logic [SelWidth-1:0]             out_sel
);

  arb_state_e          r_state;
  logic [SelWidth-1:0] r_grant;
  logic [SelWidth-1:0] r_rr_ptr;

  logic                 w_found;
  logic [SelWidth-1:0]  w_pick;
  logic                 w_arb_valid;
  logic                 w_arb_ready;
  logic                 w_arb_last;
  logic [DataWidth-1:0] w_arb_data;
  logic [SelWidth-1:0]  w_arb_sel;
  logic                 w_xfer;

  stream_arbiter_rr_pick #(
    .NumStreams(NumStreams),
    .SelWidth  (SelWidth)
  ) u_rr_pick (
    .i_valid(in_valid),
    .i_ptr  (r_rr_ptr),
    .o_found(w_found),
    .o_index(w_pick)
  );

  // Granted-input mux; everything reads zero outside LOCKED.
  always_comb begin
    w_arb_valid = 1'b0;
    w_arb_data  = '0;
    w_arb_last  = 1'b0;
    w_arb_sel   = '0;
    in_ready    = '0;
    if (r_state == ST_LOCKED) begin
      w_arb_sel = r_grant;
      for (int unsigned i = 0; i < NumStreams; i++) begin
        if (r_grant == SelWidth'(i)) begin
          w_arb_valid = in_valid[i];
          w_arb_data  = in_data[i*DataWidth +: DataWidth];
          w_arb_last  = in_last[i];
          in_ready[i] = w_arb_ready;
        end
      end
    end
  end

  assign w_xfer = w_arb_valid & w_arb_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= SelWidth'(NumStreams - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_xfer && w_arb_last) begin
            r_rr_ptr <= r_grant;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef STREAM_ARBITER_OUT_REG_EN
  // Entry 0 drives the output; entry 1 catches a beat accepted while entry 0 stalls.
  logic                 r_v0, r_v1, r_l0, r_l1;
  logic [DataWidth-1:0] r_d0, r_d1;
  logic [SelWidth-1:0]  r_s0, r_s1;

  assign w_arb_ready = ~r_v1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_l0 <= 1'b0;
      r_l1 <= 1'b0;
      r_d0 <= '0;
      r_d1 <= '0;
      r_s0 <= '0;
      r_s1 <= '0;
    end else if (!r_v0 || out_ready) begin
      if (r_v1) begin
        r_v0 <= 1'b1;
        r_d0 <= r_d1;
        r_l0 <= r_l1;
        r_s0 <= r_s1;
        r_v1 <= 1'b0;
      end else begin
        r_v0 <= w_xfer;
        r_d0 <= w_arb_data;
        r_l0 <= w_arb_last;
        r_s0 <= w_arb_sel;
      end
    end else if (w_xfer) begin
      r_v1 <= 1'b1;
      r_d1 <= w_arb_data;
      r_l1 <= w_arb_last;
      r_s1 <= w_arb_sel;
    end
  end

  assign out_valid = r_v0;
  assign out_data  = r_v0 ? r_d0 : '0;
  assign out_last  = r_v0 & r_l0;
  assign out_sel   = r_v0 ? r_s0 : '0;
`else
  assign w_arb_ready = out_ready;
  assign out_valid   = w_arb_valid;
  assign out_data    = w_arb_data;
  assign out_last    = w_arb_last;
  assign out_sel     = w_arb_sel;
`endif

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter: cycle-exact vector table plus a random-ready sequence check.
module tb_stream_arbiter;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 2;

  logic             clk;
  logic             reset;
  logic [NS-1:0]    in_valid;
  logic [NS-1:0]    in_ready;
  logic [NS*DW-1:0] in_data;
  logic [NS-1:0]    in_last;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic [SW-1:0]    out_sel;

  int checks;
  int errors;

  stream_arbiter #(
    .NumStreams(NS),
    .DataWidth (DW),
    .SelWidth  (SW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_sel  (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic [NS-1:0] v;
    logic [NS-1:0] l;
    logic          rdy;
    logic [DW-1:0] base;
    logic          e_ov;
    logic [DW-1:0] e_d;
    logic          e_l;
    logic [SW-1:0] e_sel;
    logic [NS-1:0] e_ir;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [3:0] l,
                              input logic rdy, input logic [7:0] base, input logic e_ov,
                              input logic [7:0] e_d, input logic e_l, input logic [1:0] e_sel,
                              input logic [3:0] e_ir);
    vec_t r;
    r.rst = rst; r.v = v; r.l = l; r.rdy = rdy; r.base = base;
    r.e_ov = e_ov; r.e_d = e_d; r.e_l = e_l; r.e_sel = e_sel; r.e_ir = e_ir;
    return r;
  endfunction

  // Stream i carries base+i, so the data identifies both the beat and the source.
  task automatic set_data(input logic [DW-1:0] base);
    for (int i = 0; i < NS; i++) in_data[i*DW +: DW] = base + DW'(i);
  endtask

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b1;
    set_data(8'h00);

    // rst v  l  rdy base | ov data last sel ir
    vecs[0]  = mk(0, 4'hF, 4'hF, 1, 8'h10, 0, 8'h00, 0, 0, 4'h0);
    vecs[1]  = mk(0, 4'hF, 4'hF, 1, 8'h10, 1, 8'h10, 1, 0, 4'h1);
    vecs[2]  = mk(0, 4'hF, 4'hF, 1, 8'h10, 0, 8'h00, 0, 0, 4'h0);
    vecs[3]  = mk(0, 4'hF, 4'hF, 1, 8'h10, 1, 8'h11, 1, 1, 4'h2);
    vecs[4]  = mk(0, 4'hF, 4'hF, 1, 8'h10, 0, 8'h00, 0, 0, 4'h0);
    vecs[5]  = mk(0, 4'hF, 4'hF, 1, 8'h10, 1, 8'h12, 1, 2, 4'h4);
    vecs[6]  = mk(0, 4'hF, 4'hF, 1, 8'h10, 0, 8'h00, 0, 0, 4'h0);
    vecs[7]  = mk(0, 4'hF, 4'hF, 1, 8'h10, 1, 8'h13, 1, 3, 4'h8);
    vecs[8]  = mk(0, 4'hF, 4'hF, 1, 8'h10, 0, 8'h00, 0, 0, 4'h0);
    vecs[9]  = mk(0, 4'hF, 4'hF, 1, 8'h10, 1, 8'h10, 1, 0, 4'h1);
    vecs[10] = mk(0, 4'h5, 4'h0, 1, 8'h20, 0, 8'h00, 0, 0, 4'h0);
    vecs[11] = mk(0, 4'h5, 4'h0, 1, 8'h20, 1, 8'h22, 0, 2, 4'h4);
    vecs[12] = mk(0, 4'h5, 4'h0, 1, 8'h30, 1, 8'h32, 0, 2, 4'h4);
    vecs[13] = mk(0, 4'h5, 4'h5, 1, 8'h40, 1, 8'h42, 1, 2, 4'h4);
    vecs[14] = mk(0, 4'h1, 4'h1, 1, 8'h50, 0, 8'h00, 0, 0, 4'h0);
    vecs[15] = mk(0, 4'h1, 4'h1, 1, 8'h50, 1, 8'h50, 1, 0, 4'h1);
    vecs[16] = mk(0, 4'h2, 4'h0, 1, 8'h60, 0, 8'h00, 0, 0, 4'h0);
    vecs[17] = mk(0, 4'h2, 4'h0, 1, 8'h60, 1, 8'h61, 0, 1, 4'h2);
    vecs[18] = mk(0, 4'h2, 4'h2, 0, 8'h70, 1, 8'h71, 1, 1, 4'h0);
    vecs[19] = mk(0, 4'h2, 4'h2, 1, 8'h70, 1, 8'h71, 1, 1, 4'h2);
    vecs[20] = mk(0, 4'h2, 4'h0, 1, 8'h80, 0, 8'h00, 0, 0, 4'h0);
    vecs[21] = mk(0, 4'h2, 4'h0, 1, 8'h80, 1, 8'h81, 0, 1, 4'h2);
    vecs[22] = mk(1, 4'h3, 4'h0, 1, 8'h90, 1, 8'h91, 0, 1, 4'h2);
    vecs[23] = mk(0, 4'h5, 4'h5, 1, 8'hA0, 0, 8'h00, 0, 0, 4'h0);
    vecs[24] = mk(0, 4'h5, 4'h5, 1, 8'hA0, 1, 8'hA0, 1, 0, 4'h1);
    vecs[25] = mk(0, 4'h8, 4'h0, 1, 8'hB0, 0, 8'h00, 0, 0, 4'h0);
    vecs[26] = mk(0, 4'h8, 4'h0, 1, 8'hB0, 1, 8'hB3, 0, 3, 4'h8);
    vecs[27] = mk(0, 4'h1, 4'h1, 1, 8'hC0, 0, 8'hC3, 0, 3, 4'h8);
    vecs[28] = mk(0, 4'h8, 4'h8, 1, 8'hD0, 1, 8'hD3, 1, 3, 4'h8);
    vecs[29] = mk(0, 4'h0, 4'h0, 1, 8'hE0, 0, 8'h00, 0, 0, 4'h0);

    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset: nothing requested, nothing offered.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 4'h0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
        errors++;
        $display("FAIL idle%0d: got ov=%b ir=%h d=%h sel=%0d want ov=0 ir=0 d=00 sel=0",
                 c, out_valid, in_ready, out_data, out_sel);
      end
    end

`ifndef STREAM_ARBITER_OUT_REG_EN
    // Cycle-exact vectors: round robin, packet lock, backpressure, reset mid-packet, valid drop.
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      reset     = vecs[k].rst;
      in_valid  = vecs[k].v;
      in_last   = vecs[k].l;
      out_ready = vecs[k].rdy;
      set_data(vecs[k].base);
      #1;
      checks++;
      if (out_valid !== vecs[k].e_ov || out_data !== vecs[k].e_d || out_last !== vecs[k].e_l ||
          out_sel !== vecs[k].e_sel || in_ready !== vecs[k].e_ir) begin
        errors++;
        $display("FAIL vec%0d: got ov=%b d=%h l=%b sel=%0d ir=%h want ov=%b d=%h l=%b sel=%0d ir=%h",
                 k, out_valid, out_data, out_last, out_sel, in_ready,
                 vecs[k].e_ov, vecs[k].e_d, vecs[k].e_l, vecs[k].e_sel, vecs[k].e_ir);
      end
    end
    @(negedge clk);
    reset = 1'b0;
`endif

    // All inputs hold single-beat packets; random backpressure must not lose or reorder beats.
    in_valid = 4'hF;
    in_last  = 4'hF;
    set_data(8'h10);
    n = 0;
    for (int cyc = 0; cyc < 400 && n < 12; cyc++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== 8'h10 + 8'(n % 4) || out_sel !== 2'(n % 4) || out_last !== 1'b1) begin
          errors++;
          $display("FAIL rr_seq%0d: got d=%h sel=%0d l=%b want d=%h sel=%0d l=1",
                   n, out_data, out_sel, out_last, 8'h10 + 8'(n % 4), n % 4);
        end
        n++;
      end
    end
    checks++;
    if (n < 12) begin
      errors++;
      $display("FAIL rr_seq_timeout: got %0d transfers want 12", n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
